// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: the LSU has fixed priority, the other requesters share the port round-robin.
// The winning write is registered, and a saturating counter records requester stall cycles.
module ibex_rf_wr_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned StallCntW = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        lsu_we_i,
  input  logic [4:0]                  lsu_waddr_i,
  input  logic [31:0]                 lsu_wdata_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*5-1:0]         req_waddr_i,
  input  logic [NumReq*32-1:0]        req_wdata_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        rf_we_o,
  output logic [4:0]                  rf_waddr_o,
  output logic [31:0]                 rf_wdata_o,
  output logic [$clog2(NumReq)-1:0]   rr_ptr_o,
  output logic [StallCntW-1:0]        stall_cnt_o
);

  localparam int unsigned AddrW = 5;
  localparam int unsigned DataW = 32;
  localparam int unsigned PtrW  = $clog2(NumReq);
  localparam int unsigned IncW  = $clog2(NumReq + 1);

  logic [AddrW-1:0]     waddr_arr [NumReq];
  logic [DataW-1:0]     wdata_arr [NumReq];

  logic                 req_gnt;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW:0]        idx_ext;
  logic                 grant_any;
  logic [AddrW-1:0]     sel_waddr;
  logic [DataW-1:0]     sel_wdata;
  logic [IncW-1:0]      stall_inc;
  logic [StallCntW:0]   stall_sum;

  logic                 rf_we_d,     rf_we_q;
  logic [AddrW-1:0]     rf_waddr_d,  rf_waddr_q;
  logic [DataW-1:0]     rf_wdata_d,  rf_wdata_q;
  logic [PtrW-1:0]      rr_ptr_d,    rr_ptr_q;
  logic [StallCntW-1:0] stall_cnt_d, stall_cnt_q;

  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign waddr_arr[k] = req_waddr_i[k*AddrW +: AddrW];
    assign wdata_arr[k] = req_wdata_i[k*DataW +: DataW];
  end

  // Round-robin scan starting at rr_ptr; suppressed entirely while the LSU writes.
  always_comb begin
    req_gnt     = 1'b0;
    gnt_idx     = '0;
    idx_ext     = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx_ext = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (idx_ext >= (PtrW+1)'(NumReq)) begin
        idx_ext = idx_ext - (PtrW+1)'(NumReq);
      end
      if (!lsu_we_i && !req_gnt && req_valid_i[idx_ext[PtrW-1:0]]) begin
        req_gnt = 1'b1;
        gnt_idx = idx_ext[PtrW-1:0];
      end
    end
    if (req_gnt) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_waddr = lsu_waddr_i;
    sel_wdata = lsu_wdata_i;
    if (!lsu_we_i) begin
      sel_waddr = waddr_arr[gnt_idx];
      sel_wdata = wdata_arr[gnt_idx];
    end
    grant_any = lsu_we_i | req_gnt;

    // Writes to x0 are accepted but never reach the register file.
    rf_we_d    = grant_any & (sel_waddr != '0);
    rf_waddr_d = grant_any ? sel_waddr : rf_waddr_q;
    rf_wdata_d = grant_any ? sel_wdata : rf_wdata_q;

    rr_ptr_d = rr_ptr_q;
    if (req_gnt) begin
      rr_ptr_d = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + PtrW'(1);
    end

    stall_inc = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      stall_inc = stall_inc + IncW'(req_valid_i[k] & ~req_ready_o[k]);
    end
    stall_sum   = {1'b0, stall_cnt_q} + (StallCntW+1)'(stall_inc);
    stall_cnt_d = stall_sum[StallCntW] ? '1 : stall_sum[StallCntW-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign rr_ptr_o    = rr_ptr_q;
  assign stall_cnt_o = stall_cnt_q;

  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_ready_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_ready_o & ~req_valid_i) == '0);
  a_lsu_blocks_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_we_i |-> (req_ready_o == '0));
  a_we_not_x0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we_o |-> (rf_waddr_o != '0));

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Scoreboard bench for ibex_rf_wr_arbiter (NumReq=2, StallCntW=8): a reference model predicts
// ready, the registered RF write, the round-robin pointer and the stall count on every cycle.
module tb_ibex_rf_wr_arbiter;

  localparam int unsigned N      = 2;
  localparam int unsigned SW     = 8;
  localparam int          SatMax = 255;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            lsu_we_i;
  logic [4:0]      lsu_waddr_i;
  logic [31:0]     lsu_wdata_i;
  logic [N-1:0]    req_valid_i;
  logic [N*5-1:0]  req_waddr_i;
  logic [N*32-1:0] req_wdata_i;
  logic [N-1:0]    req_ready_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [31:0]     rf_wdata_o;
  logic [0:0]      rr_ptr_o;
  logic [SW-1:0]   stall_cnt_o;

  ibex_rf_wr_arbiter #(.NumReq(N), .StallCntW(SW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .lsu_we_i    (lsu_we_i),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .req_valid_i (req_valid_i),
    .req_waddr_i (req_waddr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rr_ptr_o    (rr_ptr_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_tests = 0;
  int         n_fail  = 0;
  wr_t        sb[$];
  logic [0:0] m_rr;
  int         m_stall;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;
  logic [1:0] exp_ready, obs_ready;
  wr_t        exp_wr, obs_wr;
  logic [0:0] obs_rr;
  logic [7:0] obs_stall;

  function automatic logic [1:0] mdl_ready(input logic lsu, input logic [1:0] v, input logic [0:0] r);
    if (lsu) return 2'b00;
    if (r == 1'b0) begin
      if (v[0]) return 2'b01;
      if (v[1]) return 2'b10;
    end else begin
      if (v[1]) return 2'b10;
      if (v[0]) return 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_rr    = 1'b0;
    m_stall = 0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic drive(input logic lsu, input logic [4:0] la, input logic [31:0] ld,
                       input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    lsu_we_i    = lsu;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
    req_valid_i = v;
    req_waddr_i = {a1, a0};
    req_wdata_i = {d1, d0};
  endtask

  // Predict this cycle, push the expected registered write, clock once and capture outputs.
  task automatic step();
    wr_t e;
    int  inc;
    #1;
    obs_ready = req_ready_o;
    exp_ready = mdl_ready(lsu_we_i, req_valid_i, m_rr);
    e = {1'b0, m_waddr, m_wdata};
    if (lsu_we_i) begin
      e = {lsu_waddr_i != 5'd0, lsu_waddr_i, lsu_wdata_i};
    end else if (exp_ready[0]) begin
      e = {req_waddr_i[4:0] != 5'd0, req_waddr_i[4:0], req_wdata_i[31:0]};
      m_rr = 1'b1;
    end else if (exp_ready[1]) begin
      e = {req_waddr_i[9:5] != 5'd0, req_waddr_i[9:5], req_wdata_i[63:32]};
      m_rr = 1'b0;
    end
    m_waddr = e.waddr;
    m_wdata = e.wdata;
    inc = int'(req_valid_i[0] & ~exp_ready[0]) + int'(req_valid_i[1] & ~exp_ready[1]);
    m_stall = (m_stall + inc > SatMax) ? SatMax : m_stall + inc;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    obs_wr    = {rf_we_o, rf_waddr_o, rf_wdata_o};
    obs_rr    = rr_ptr_o;
    obs_stall = stall_cnt_o;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    model_reset();
    rst_ni = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    n_tests++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, rr_ptr_o, stall_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: got we=%b a=%0d d=%h rr=%0d st=%0d exp all 0",
               rf_we_o, rf_waddr_o, rf_wdata_o, rr_ptr_o, stall_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_wr = sb.pop_front();
      n_tests++;
      if (obs_ready !== 2'b00) begin
        n_fail++; $display("FAIL reset_ready cyc=%0d got=%b exp=00", i, obs_ready);
      end
      n_tests++;
      if ({obs_wr, obs_rr, obs_stall} !== '0 || obs_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got wr=%h rr=%0d st=%0d exp all 0", i, obs_wr, obs_rr, obs_stall);
      end
    end
  endtask

  task automatic test_round_robin();
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd5, 32'hAAAA_0000, 5'd6, 32'hBBBB_0001);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_wr = sb.pop_front();
      n_tests++;
      if (obs_ready !== exp_ready || obs_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", i, obs_ready, exp_ready);
      end
      n_tests++;
      if (obs_wr !== exp_wr) begin
        n_fail++; $display("FAIL rr_write cyc=%0d got=%h exp=%h", i, obs_wr, exp_wr);
      end
      n_tests++;
      if (obs_rr !== m_rr || obs_stall !== 8'(m_stall) || obs_stall !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL rr_state cyc=%0d got rr=%0d st=%0d exp rr=%0d st=%0d", i, obs_rr, obs_stall, m_rr, m_stall);
      end
    end
  endtask

  task automatic test_lsu_priority();
    logic [0:0] rr_before;
    rr_before = m_rr;
    drive(1'b1, 5'd7, 32'h1234_5678, 2'b01, 5'd3, 32'hCAFE_0003, 5'd0, 32'd0);
    step();
    exp_wr = sb.pop_front();
    n_tests++;
    if (obs_ready !== 2'b00) begin
      n_fail++; $display("FAIL lsu_ready got=%b exp=00", obs_ready);
    end
    n_tests++;
    if (obs_wr !== exp_wr || obs_wr !== {1'b1, 5'd7, 32'h1234_5678}) begin
      n_fail++; $display("FAIL lsu_write got=%h exp=%h", obs_wr, exp_wr);
    end
    n_tests++;
    if (obs_rr !== rr_before || obs_stall !== 8'(m_stall)) begin
      n_fail++;
      $display("FAIL lsu_state got rr=%0d st=%0d exp rr=%0d st=%0d", obs_rr, obs_stall, rr_before, m_stall);
    end
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd3, 32'hCAFE_0003, 5'd0, 32'd0);
    step();
    exp_wr = sb.pop_front();
    n_tests++;
    if (obs_ready !== 2'b01 || obs_wr !== exp_wr || obs_rr !== m_rr) begin
      n_fail++;
      $display("FAIL lsu_after got rdy=%b wr=%h rr=%0d exp rdy=01 wr=%h rr=%0d", obs_ready, obs_wr, obs_rr, exp_wr, m_rr);
    end
  endtask

  task automatic test_x0_write();
    drive(1'b0, 5'd0, 32'd0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    step();
    exp_wr = sb.pop_front();
    n_tests++;
    if (obs_ready !== 2'b10) begin
      n_fail++; $display("FAIL x0_ready got=%b exp=10", obs_ready);
    end
    n_tests++;
    if (obs_wr !== exp_wr || obs_wr.we !== 1'b0) begin
      n_fail++; $display("FAIL x0_write got=%h exp=%h", obs_wr, exp_wr);
    end
    n_tests++;
    if (obs_rr !== 1'b0) begin
      n_fail++; $display("FAIL x0_rr got=%0d exp=0", obs_rr);
    end
  endtask

  task automatic test_stall_saturation();
    int errs;
    errs = 0;
    drive(1'b1, 5'd12, 32'h0BAD_F00D, 2'b01, 5'd4, 32'h4444_4444, 5'd0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      exp_wr = sb.pop_front();
      n_tests++;
      if (obs_ready !== 2'b00 || obs_wr !== exp_wr || obs_stall !== 8'(m_stall) || obs_rr !== m_rr) begin
        n_fail++;
        if (errs++ < 5)
          $display("FAIL sat_cycle cyc=%0d got rdy=%b st=%0d rr=%0d exp rdy=00 st=%0d rr=%0d",
                   i, obs_ready, obs_stall, obs_rr, m_stall, m_rr);
      end
    end
    n_tests++;
    if (obs_stall !== 8'd255) begin
      n_fail++; $display("FAIL sat_final got=%0d exp=255", obs_stall);
    end
  endtask

  task automatic test_back_to_back_reset();
    drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd9, 32'h9999_0009, 5'd0, 32'd0);
    step();
    exp_wr = sb.pop_front();
    n_tests++;
    if (obs_wr !== exp_wr || obs_wr.we !== 1'b1 || obs_rr !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got wr=%h rr=%0d exp wr=%h rr=1", obs_wr, obs_rr, exp_wr);
    end
    rst_ni = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1;
    n_tests++;
    if (rf_we_o !== 1'b0 || rr_ptr_o !== 1'b0 || stall_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset got we=%b rr=%0d st=%0d exp 0 0 0", rf_we_o, rr_ptr_o, stall_cnt_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd5, 32'hAAAA_0000, 5'd6, 32'hBBBB_0001);
    step();
    exp_wr = sb.pop_front();
    n_tests++;
    if (obs_ready !== 2'b01 || obs_wr !== exp_wr || obs_wr !== {1'b1, 5'd5, 32'hAAAA_0000}) begin
      n_fail++;
      $display("FAIL post_reset got rdy=%b wr=%h exp rdy=01 wr=%h", obs_ready, obs_wr, exp_wr);
    end
    n_tests++;
    if (obs_rr !== m_rr || obs_stall !== 8'(m_stall)) begin
      n_fail++;
      $display("FAIL post_state got rr=%0d st=%0d exp rr=%0d st=%0d", obs_rr, obs_stall, m_rr, m_stall);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lsu_priority();
    test_x0_write();
    test_stall_saturation();
    test_back_to_back_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ibex_rf_wr_arbiter.md
Name: ibex_rf_wr_arbiter

Overview:
- Shares the single register-file write port between the LSU load-return path and NumReq other writeback requesters (ID/EX result path, multi-cycle units).
- Sits between the writeback stage and the register file.
- The LSU has absolute priority because load data cannot be stalled. Other requesters use a valid/ready handshake and are served round-robin.
- The selected write is registered, so the RF write occurs one cycle after acceptance. A saturating stall counter is provided for performance monitoring.

Parameters:
- NumReq, 2, number of non-LSU requesters; legal range 2..4.
- StallCntW, 8, width of the saturating stall counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset: one clock; reset is asynchronous and active-low.
- lsu_we_i  input  1  LSU load-data write request; cannot be back-pressured.
- lsu_waddr_i  input  5  LSU destination register.
- lsu_wdata_i  input  32  LSU write data.
- req_valid_i  input  NumReq  requester write valid, one bit per requester.
- req_waddr_i  input  NumReq*5  requester destination registers; requester k occupies bits [5k+4:5k].
- req_wdata_i  input  NumReq*32  requester data; requester k occupies bits [32k+31:32k].
- req_ready_o  output  NumReq  acceptance, one-hot or zero.
- rf_we_o  output  1  registered RF write enable.
- rf_waddr_o  output  5  registered RF write address.
- rf_wdata_o  output  32  registered RF write data.
- rr_ptr_o  output  $clog2(NumReq)  current round-robin start index (debug/DV visibility).
- stall_cnt_o  output  StallCntW  saturating count of stall cycles.

Behaviour:
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, rr_ptr=0, stall_cnt_o=0. All state uses asynchronous reset.
- Reset asserted mid-operation clears any pending registered write; no RF write occurs in the reset cycle.
- req_ready_o is combinational and does not reset.
- Arbitration (combinational, same cycle):
  - If lsu_we_i=1: the LSU wins and req_ready_o=0.
  - Otherwise: grant the first k with req_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NumReq. req_ready_o[k]=1 for that k only.
  - If nothing is valid, no grant and req_ready_o=0.
- req_ready_o[k] never asserts unless req_valid_i[k]=1 in the same cycle.
- Handshake: a transfer occurs when req_valid_i[k] & req_ready_o[k]. Requesters hold valid, address and data stable until accepted; valid is never withdrawn before acceptance.
- Round-robin update:
  - On a non-LSU grant to k, rr_ptr <= (k+1) mod NumReq. Wrap from NumReq-1 to 0.
  - Unchanged on an LSU grant or an idle cycle.
- Output register, latency 1:
  - rf_we_o <= grant_any & (sel_waddr != 0), where grant_any = LSU grant or requester grant.
  - rf_waddr_o / rf_wdata_o <= selected address/data on any grant; they hold their previous value otherwise.
  - A write to x0 is accepted (ready=1, rr_ptr advances) but produces rf_we_o=0 the next cycle.
- Stall counter:
  - Increments by 1 in any cycle where (|req_valid_i) and no requester is granted. This covers the LSU-preemption case.
  - Also increments for each valid-but-ungranted requester beyond the first; adds popcount(req_valid_i & ~req_ready_o), saturating.
  - Saturates at 2^StallCntW-1 and never wraps.
- Simultaneous events: LSU write plus all requesters valid → LSU written, requesters all stalled, stall counter increments by popcount(req_valid_i).
- Assertions:
  - $onehot0(req_ready_o).
  - If lsu_we_i then req_ready_o==0.
  - rf_we_o implies rf_waddr_o!=0.

Test Plan:
- Reset release with req_valid_i=0, lsu_we_i=0 → all outputs 0, rr_ptr_o=0, stall_cnt_o=0 for 10 cycles.
- NumReq=2, both valid continuously (req0 waddr=5 data=0xAAAA0000, req1 waddr=6 data=0xBBBB0001) → ready alternates 01,10,01,10; rf_waddr_o sequence 5,6,5,6 one cycle later; stall_cnt_o increments by 1 per cycle.
- lsu_we_i=1 (waddr=7, data=0x12345678) with req0 valid → req_ready_o=00; next cycle rf_we_o=1, rf_waddr_o=7, rf_wdata_o=0x12345678; req0 granted the following cycle; rr_ptr_o unchanged across the LSU cycle.
- req1 valid with waddr=0, data=0xFFFFFFFF → req_ready_o=10, rr_ptr_o becomes 0, next cycle rf_we_o=0.
- StallCntW=8, LSU asserted continuously with req0 valid for 300 cycles → stall_cnt_o reaches 255 and holds.
- Assert rst_ni low for 1 cycle while rf_we_o=1 and rr_ptr_o=1 → rf_we_o drops immediately (asynchronously), rr_ptr_o=0, stall_cnt_o=0; first grant after release goes to req0.
